ifmap_glb_ctrl: RTL and testbench

Sequencer for the ifmap global buffer. It runs in two phases. In the load phase it drains 64-bit words from the off-chip input FIFO into GLB port A, four ifmap values per write. In the stream phase it reads a configured window of 16-bit values through GLB port B and delivers them to the PE-array multicast network on a valid/ready stream. It sits between the input FIFO, the ifmap GLB and the ifmap NoC.

---
 rtl/ifmap_glb_ctrl_pkg.sv | 19 +
 rtl/ifmap_glb_ctrl_if.sv | 36 +++
 rtl/ifmap_glb_ctrl_rd_skid.sv | 35 +++
 rtl/ifmap_glb_ctrl.sv | 78 +++++++
 tb/tb_ifmap_glb_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifmap_glb_ctrl_pkg.sv
// ifmap_glb_ctrl_pkg: shared widths, FSM state type and config record for the ifmap GLB sequencer
package ifmap_glb_ctrl_pkg;
  localparam int FIFO_WIDTH = 64;
  localparam int DATA_WIDTH = 16;
  localparam int DEPTH = 154588;
  localparam int ADDR = $clog2(DEPTH);
  localparam int SKID_DEPTH = 2;
  localparam int WORD_LANES = FIFO_WIDTH / DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} ctrl_state_t;
  typedef struct packed {
    logic [ADDR-1:0] load_base;
    logic [ADDR-1:0] load_words;
    logic [ADDR-1:0] rd_base;
    logic [ADDR-1:0] rd_len;
  } ctrl_cfg_t;
  function automatic logic [ADDR-1:0] word_addr(input logic [ADDR-1:0] base, input logic [ADDR-1:0] idx);
    return base + idx * ADDR'(WORD_LANES);
  endfunction
endpackage

// File: rtl/ifmap_glb_ctrl_if.sv
// ifmap_glb_ctrl_if: job config, input FIFO, GLB ports A/B, NoC stream and status of the ifmap sequencer
interface ifmap_glb_ctrl_if;
  import ifmap_glb_ctrl_pkg::*;
  logic                  start;
  logic [ADDR-1:0]       cfg_load_base;
  logic [ADDR-1:0]       cfg_load_words;
  logic [ADDR-1:0]       cfg_rd_base;
  logic [ADDR-1:0]       cfg_rd_len;
  logic [FIFO_WIDTH-1:0] fifo_rdata;
  logic                  fifo_empty;
  logic                  fifo_re;
  logic [FIFO_WIDTH-1:0] glb_wdata_a;
  logic                  glb_we_a;
  logic                  glb_re_a;
  logic [ADDR-1:0]       glb_addr_a;
  logic                  glb_re_b;
  logic [ADDR-1:0]       glb_addr_b;
  logic [DATA_WIDTH-1:0] glb_rdata_b;
  logic [DATA_WIDTH-1:0] ifmap_data;
  logic                  ifmap_valid;
  logic                  ifmap_ready;
  logic                  busy;
  logic                  done;
  modport master (
    input  start, cfg_load_base, cfg_load_words, cfg_rd_base, cfg_rd_len,
    input  fifo_rdata, fifo_empty, glb_rdata_b, ifmap_ready,
    output fifo_re, glb_wdata_a, glb_we_a, glb_re_a, glb_addr_a, glb_re_b, glb_addr_b,
    output ifmap_data, ifmap_valid, busy, done
  );
  modport slave (
    output start, cfg_load_base, cfg_load_words, cfg_rd_base, cfg_rd_len,
    output fifo_rdata, fifo_empty, glb_rdata_b, ifmap_ready,
    input  fifo_re, glb_wdata_a, glb_we_a, glb_re_a, glb_addr_a, glb_re_b, glb_addr_b,
    input  ifmap_data, ifmap_valid, busy, done
  );
endinterface

// File: rtl/ifmap_glb_ctrl_rd_skid.sv
// glb_rd_skid: 2-entry FIFO holding port-B read data until the NoC accepts it
module glb_rd_skid
  import ifmap_glb_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);
  logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d, keep;
  // keep = entries surviving this cycle's pop; a push lands right behind them
  always_comb begin
    keep = cnt_q - {1'b0, pop};
    cnt_d = keep + {1'b0, push};
    ent0_d = (pop && cnt_q == 2'd2) ? ent1_q : (push && keep == 2'd0) ? push_data : ent0_q;
    ent1_d = (push && keep == 2'd1) ? push_data : ent1_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end
  assign head = ent0_q;
  assign count = cnt_q;
endmodule

// File: rtl/ifmap_glb_ctrl.sv
// ifmap_glb_ctrl: loads FIFO words into GLB port A, then streams a value window from port B to the NoC
module ifmap_glb_ctrl
  import ifmap_glb_ctrl_pkg::*;
(
  input logic core_clk,
  input logic reset,
  ifmap_glb_ctrl_if.master bus
);
  ctrl_state_t state_q, state_d;
  ctrl_cfg_t cfg_q, cfg_d;
  logic [ADDR-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, ocnt_q, ocnt_d;
  logic infl_q, infl_d;
  logic wr, rd, pop;
  logic [1:0] sk_cnt;
  logic [DATA_WIDTH-1:0] sk_head;
  glb_rd_skid u_skid (
    .clk(core_clk),
    .rst(reset),
    .push(infl_q),
    .pop(pop),
    .push_data(bus.glb_rdata_b),
    .head(sk_head),
    .count(sk_cnt)
  );
  // a read may issue whenever post-pop occupancy plus the in-flight read leaves room
  always_comb begin
    state_d = state_q;
    cfg_d = cfg_q;
    wr = state_q == LOAD && !bus.fifo_empty;
    pop = state_q == STREAM && sk_cnt != 2'd0 && bus.ifmap_ready;
    rd = state_q == STREAM && rcnt_q < cfg_q.rd_len &&
         (sk_cnt - {1'b0, pop} + {1'b0, infl_q}) < 2'(SKID_DEPTH);
    infl_d = rd;
    wcnt_d = wcnt_q + ADDR'(wr);
    rcnt_d = rcnt_q + ADDR'(rd);
    ocnt_d = ocnt_q + ADDR'(pop);
    unique case (state_q)
      IDLE: if (bus.start) begin
        cfg_d = '{bus.cfg_load_base, bus.cfg_load_words, bus.cfg_rd_base, bus.cfg_rd_len};
        wcnt_d = '0;
        rcnt_d = '0;
        ocnt_d = '0;
        state_d = bus.cfg_load_words != '0 ? LOAD : bus.cfg_rd_len != '0 ? STREAM : FINISH;
      end
      LOAD: if (wr && wcnt_d == cfg_q.load_words) state_d = cfg_q.rd_len != '0 ? STREAM : FINISH;
      STREAM: if (ocnt_d == cfg_q.rd_len) state_d = FINISH;
      FINISH: state_d = IDLE;
    endcase
  end
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_q <= '0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      ocnt_q <= '0;
      infl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q <= cfg_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      ocnt_q <= ocnt_d;
      infl_q <= infl_d;
    end
  end
  assign bus.fifo_re = wr;
  assign bus.glb_we_a = wr;
  assign bus.glb_re_a = 1'b0;
  assign bus.glb_wdata_a = state_q == LOAD ? bus.fifo_rdata : '0;
  assign bus.glb_addr_a = state_q == LOAD ? word_addr(cfg_q.load_base, wcnt_q) : '0;
  assign bus.glb_re_b = rd;
  assign bus.glb_addr_b = rd ? cfg_q.rd_base + rcnt_q : '0;
  assign bus.ifmap_valid = sk_cnt != 2'd0;
  assign bus.ifmap_data = sk_cnt != 2'd0 ? sk_head : '0;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == FINISH;
endmodule

// File: tb/tb_ifmap_glb_ctrl.sv
// tb_ifmap_glb_ctrl: scoreboard bench for the ifmap GLB sequencer with FIFO and GLB port-B models
module tb_ifmap_glb_ctrl;
  import ifmap_glb_ctrl_pkg::*;
  logic core_clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  ifmap_glb_ctrl_if bus();
  ifmap_glb_ctrl dut (.core_clk(core_clk), .reset(reset), .bus(bus));
  always #5 core_clk = ~core_clk;
  // GLB port B: address n holds value n, one-cycle read latency, junk when not reading
  always @(posedge core_clk) bus.glb_rdata_b <= bus.glb_re_b ? DATA_WIDTH'(bus.glb_addr_b) : 16'hdead;

  function automatic logic [FIFO_WIDTH-1:0] word_of(input int i);
    return {16'(4*i+4), 16'(4*i+3), 16'(4*i+2), 16'(4*i+1)};
  endfunction

  task automatic run_job(input int lb, lw, rb, rl, input bit gaps, input int stall_at, stall_len,
                         output int first_wr, last_wr, first_re, last_re, first_beat, last_beat,
                         output int done_cyc, n_wr, n_re, n_beat, max_out);
    logic [ADDR+FIFO_WIDTH-1:0] exp_wr[$];
    logic [ADDR-1:0] exp_re[$];
    logic [DATA_WIDTH-1:0] exp_beat[$];
    logic [ADDR+FIFO_WIDTH-1:0] ew;
    logic [ADDR-1:0] er;
    logic [DATA_WIDTH-1:0] eb, held_data;
    int widx;
    bit held, fin;
    widx = 0; held = 0; fin = 0; held_data = '0;
    first_wr = -1; last_wr = -1; first_re = -1; last_re = -1; first_beat = -1; last_beat = -1;
    done_cyc = -1; n_wr = 0; n_re = 0; n_beat = 0; max_out = 0;
    for (int i = 0; i < lw; i++) exp_wr.push_back({ADDR'(lb + 4*i), word_of(i)});
    for (int i = 0; i < rl; i++) begin
      exp_re.push_back(ADDR'(rb + i));
      exp_beat.push_back(DATA_WIDTH'(rb + i));
    end
    @(negedge core_clk);
    bus.cfg_load_base = ADDR'(lb);
    bus.cfg_load_words = ADDR'(lw);
    bus.cfg_rd_base = ADDR'(rb);
    bus.cfg_rd_len = ADDR'(rl);
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      bus.fifo_empty = (widx >= lw) || (gaps && cyc % 2 == 0);
      bus.fifo_rdata = word_of(widx);
      bus.ifmap_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      checks++;
      if (bus.fifo_re !== bus.glb_we_a || (bus.glb_we_a && bus.fifo_empty)) begin
        errors++;
        $display("FAIL fifo_handshake cyc=%0d: fifo_re=%b we_a=%b fifo_empty=%b, required fifo_re==we_a and no write while empty",
                 cyc, bus.fifo_re, bus.glb_we_a, bus.fifo_empty);
      end
      if (bus.glb_we_a) begin
        n_wr++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        widx++;
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cyc=%0d: addr_a=%0d, required no write", cyc, bus.glb_addr_a);
        end else begin
          ew = exp_wr.pop_front();
          if ({bus.glb_addr_a, bus.glb_wdata_a} !== ew) begin
            errors++;
            $display("FAIL write cyc=%0d: addr_a=%0d data=%h, required addr_a=%0d data=%h",
                     cyc, bus.glb_addr_a, bus.glb_wdata_a, ew[ADDR+FIFO_WIDTH-1:FIFO_WIDTH], ew[FIFO_WIDTH-1:0]);
          end
        end
      end
      if (bus.glb_re_b) begin
        n_re++;
        if (first_re < 0) first_re = cyc;
        last_re = cyc;
        checks++;
        er = exp_re.size() != 0 ? exp_re.pop_front() : '1;
        if (bus.glb_addr_b !== er || bus.glb_we_a !== 1'b0) begin
          errors++;
          $display("FAIL read cyc=%0d: addr_b=%0d we_a=%b, required addr_b=%0d we_a=0", cyc, bus.glb_addr_b, bus.glb_we_a, er);
        end
      end
      if (held) begin
        checks++;
        if (bus.ifmap_valid !== 1'b1 || bus.ifmap_data !== held_data) begin
          errors++;
          $display("FAIL stall_stable cyc=%0d: valid=%b data=%h, required valid=1 data=%h", cyc, bus.ifmap_valid, bus.ifmap_data, held_data);
        end
      end
      if (bus.ifmap_valid && bus.ifmap_ready) begin
        n_beat++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        checks++;
        eb = exp_beat.size() != 0 ? exp_beat.pop_front() : 16'hbeef;
        if (bus.ifmap_data !== eb) begin
          errors++;
          $display("FAIL beat cyc=%0d: ifmap_data=%h, required %h", cyc, bus.ifmap_data, eb);
        end
      end
      held = bus.ifmap_valid && !bus.ifmap_ready;
      held_data = bus.ifmap_data;
      if (n_re - n_beat > max_out) max_out = n_re - n_beat;
      if (bus.done) begin
        fin = 1;
        done_cyc = cyc;
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL done_busy cyc=%0d: busy=%b, required 1", cyc, bus.busy);
        end
      end
      @(negedge core_clk);
      bus.start = 1'b0;
    end
    bus.fifo_empty = 1'b1;
    bus.ifmap_ready = 1'b1;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL done_timeout: no done within 200 cycles, required a done pulse");
    end
    checks++;
    if (exp_wr.size() + exp_re.size() + exp_beat.size() != 0) begin
      errors++;
      $display("FAIL leftover: writes=%0d reads=%0d beats=%0d still expected, required 0", exp_wr.size(), exp_re.size(), exp_beat.size());
    end
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.cfg_load_base = '0; bus.cfg_load_words = '0; bus.cfg_rd_base = '0; bus.cfg_rd_len = '0;
    bus.fifo_empty = 1'b0;
    bus.fifo_rdata = 64'hffff_eeee_dddd_cccc;
    bus.ifmap_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge core_clk);
    checks++;
    if ({bus.fifo_re, bus.glb_we_a, bus.glb_re_a, bus.glb_re_b, bus.ifmap_valid, bus.busy, bus.done,
         bus.glb_addr_a, bus.glb_addr_b, bus.glb_wdata_a, bus.ifmap_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: re=%b we=%b wdata=%h busy=%b, required all outputs 0", bus.fifo_re, bus.glb_we_a, bus.glb_wdata_a, bus.busy);
    end
    reset = 1'b0;
    @(negedge core_clk);
    #1;
    checks++;
    if ({bus.fifo_re, bus.glb_we_a, bus.glb_re_b, bus.busy, bus.done, bus.glb_wdata_a} !== '0) begin
      errors++;
      $display("FAIL idle_outputs: re=%b we=%b wdata=%h busy=%b, required all 0 in IDLE", bus.fifo_re, bus.glb_we_a, bus.glb_wdata_a, bus.busy);
    end
    bus.fifo_empty = 1'b1;
  endtask

  task automatic test_load();
    int fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo;
    run_job(0, 3, 0, 0, 0, 0, 0, fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo);
    checks++;
    if (nw !== 3 || fw !== 1 || lw_ !== 3 || nr !== 0) begin
      errors++;
      $display("FAIL load_timing: writes=%0d first=%0d last=%0d reads=%0d, required 3 1 3 0", nw, fw, lw_, nr);
    end
    checks++;
    if (dc !== 4) begin
      errors++;
      $display("FAIL load_done: done at cycle %0d, required 4", dc);
    end
    run_job(32, 2, 0, 0, 0, 0, 0, fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo);
    checks++;
    if (nw !== 2 || dc !== 3) begin
      errors++;
      $display("FAIL load_base32: writes=%0d done=%0d, required 2 3", nw, dc);
    end
  endtask

  task automatic test_fifo_gaps();
    int fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo;
    run_job(0, 2, 0, 0, 1, 0, 0, fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo);
    checks++;
    if (nw !== 2 || fw !== 1 || lw_ !== 3 || dc !== 4) begin
      errors++;
      $display("FAIL fifo_gaps: writes=%0d first=%0d last=%0d done=%0d, required 2 1 3 4", nw, fw, lw_, dc);
    end
  endtask

  task automatic test_stream();
    int fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo;
    run_job(0, 0, 5, 4, 0, 0, 0, fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo);
    checks++;
    if (nr !== 4 || fr !== 1 || lr !== 4 || nw !== 0) begin
      errors++;
      $display("FAIL stream_reads: reads=%0d first=%0d last=%0d writes=%0d, required 4 1 4 0", nr, fr, lr, nw);
    end
    checks++;
    if (nb !== 4 || fb !== 3 || lb_ !== 6 || dc !== 7) begin
      errors++;
      $display("FAIL stream_beats: beats=%0d first=%0d last=%0d done=%0d, required 4 3 6 7", nb, fb, lb_, dc);
    end
  endtask

  task automatic test_stall();
    int fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo;
    run_job(0, 0, 20, 6, 0, 4, 5, fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo);
    checks++;
    if (mo > 2 || nb !== 6 || nr !== 6) begin
      errors++;
      $display("FAIL stall_outstanding: max_out=%0d beats=%0d reads=%0d, required <=2 6 6", mo, nb, nr);
    end
    checks++;
    if (lb_ < 9 || dc !== lb_ + 1) begin
      errors++;
      $display("FAIL stall_done: last_beat=%0d done=%0d, required last_beat>=9 and done=last_beat+1", lb_, dc);
    end
  endtask

  task automatic test_back_to_back();
    int fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo;
    run_job(8, 2, 8, 3, 0, 0, 0, fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo);
    checks++;
    if (nw !== 2 || lw_ !== 2 || fr !== 3 || lb_ !== 7 || dc !== 8) begin
      errors++;
      $display("FAIL load_then_stream: writes=%0d last_wr=%0d first_re=%0d last_beat=%0d done=%0d, required 2 2 3 7 8", nw, lw_, fr, lb_, dc);
    end
  endtask

  task automatic test_empty_job();
    int fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo;
    run_job(0, 0, 0, 0, 0, 0, 0, fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo);
    checks++;
    if (dc !== 1 || nw !== 0 || nr !== 0 || nb !== 0) begin
      errors++;
      $display("FAIL empty_job: done=%0d writes=%0d reads=%0d beats=%0d, required 1 0 0 0", dc, nw, nr, nb);
    end
  endtask

  task automatic test_reset_mid_stream();
    int fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo;
    @(negedge core_clk);
    bus.cfg_load_words = '0;
    bus.cfg_rd_base = ADDR'(40);
    bus.cfg_rd_len = ADDR'(8);
    bus.ifmap_ready = 1'b1;
    bus.start = 1'b1;
    @(negedge core_clk);
    bus.start = 1'b0;
    #1;
    checks++;
    if (bus.glb_re_b !== 1'b1 || bus.glb_addr_b !== ADDR'(40)) begin
      errors++;
      $display("FAIL mid_first_read: re_b=%b addr_b=%0d, required 1 40", bus.glb_re_b, bus.glb_addr_b);
    end
    @(negedge core_clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.fifo_re, bus.glb_we_a, bus.glb_re_b, bus.ifmap_valid, bus.busy, bus.done,
         bus.glb_addr_b, bus.ifmap_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset: re_b=%b valid=%b busy=%b done=%b, required all 0", bus.glb_re_b, bus.ifmap_valid, bus.busy, bus.done);
    end
    @(negedge core_clk);
    #1;
    checks++;
    if (bus.ifmap_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold: valid=%b busy=%b done=%b, required 0 0 0", bus.ifmap_valid, bus.busy, bus.done);
    end
    reset = 1'b0;
    run_job(0, 0, 60, 3, 0, 0, 0, fw, lw_, fr, lr, fb, lb_, dc, nw, nr, nb, mo);
    checks++;
    if (fr !== 1 || nb !== 3 || fb !== 3 || dc !== 6) begin
      errors++;
      $display("FAIL after_reset_job: first_re=%0d beats=%0d first_beat=%0d done=%0d, required 1 3 3 6", fr, nb, fb, dc);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_fifo_gaps();
    test_stream();
    test_stall();
    test_back_to_back();
    test_empty_job();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
